// File: rtl/systolic_array_ws.sv
// systolic_array_ws: N x N weight-stationary systolic matrix unit.
// Optional SYSTOLIC_RELU_EN clamps every result at zero before the output register.
module systolic_array_ws #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [N*DATA_W-1:0] w_row,
  input  logic                w_reload,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [N*DATA_W-1:0] a_vec,
  input  logic                a_last,
  output logic                out_valid,
  output logic [N*ACC_W-1:0]  out_vec,
  output logic                out_last,
  output logic                busy
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, STREAM, DRAIN} state_t;

  localparam int CW = $clog2(2*N+1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(N-1);
  localparam logic [CW-1:0] DRAIN_END = CW'(2*N-1);

  state_t                   state_q, state_d;
  logic [CW-1:0]            row_cnt_q, row_cnt_d;
  logic [CW-1:0]            drain_cnt_q, drain_cnt_d;
  logic                     w_acc, a_acc;
  logic signed [DATA_W-1:0] w_q [N][N];
  logic signed [DATA_W-1:0] a_in_q [N];
  logic signed [DATA_W-1:0] a_left [N];
  logic signed [DATA_W-1:0] act_w [N][N];
  logic signed [ACC_W-1:0]  psum_w [N][N];
  logic signed [ACC_W-1:0]  col_out [N];
  logic signed [ACC_W-1:0]  res [N];
  logic [2*N-1:0]           vld_q, lst_q;
  logic                     out_valid_q, out_last_q;
  logic [N*ACC_W-1:0]       out_vec_q;

  // State and sequencing counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next state, handshakes and accept strobes.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    w_ready     = 1'b0;
    a_ready     = 1'b0;
    busy        = 1'b0;
    w_acc       = 1'b0;
    a_acc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_acc     = 1'b1;
          row_cnt_d = row_cnt_q + 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_valid) begin
          w_acc     = 1'b1;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == LAST_ROW) state_d = READY;
        end
      end
      READY: begin
        a_ready = 1'b1;
        if (w_reload) begin
          row_cnt_d = '0;
          state_d   = IDLE;
        end else if (a_valid) begin
          a_acc       = 1'b1;
          drain_cnt_d = '0;
          state_d     = a_last ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        a_ready = 1'b1;
        busy    = 1'b1;
        if (a_valid) begin
          a_acc = 1'b1;
          if (a_last) begin
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_q == DRAIN_END) state_d = READY;
        else drain_cnt_d = drain_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stationary weights, written one row per accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) w_q[r][c] <= '0;
    end else if (w_acc) begin
      for (int r = 0; r < N; r++)
        if (row_cnt_q == CW'(r))
          for (int c = 0; c < N; c++)
            w_q[r][c] <= w_row[c*DATA_W +: DATA_W];
    end
  end

  // Input register (zero on bubbles) and valid/last tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) a_in_q[k] <= '0;
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        a_in_q[k] <= a_acc ? a_vec[k*DATA_W +: DATA_W] : '0;
      vld_q <= {vld_q[2*N-2:0], a_acc};
      lst_q <= {lst_q[2*N-2:0], a_acc & a_last};
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_skew
    if (k == 0) begin : g_d0
      assign a_left[k] = a_in_q[k];
    end else begin : g_dn
      logic signed [DATA_W-1:0] sk_q [k];
      // Delay row k by k cycles so it meets the psum wave.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < k; i++) sk_q[i] <= '0;
        end else begin
          sk_q[0] <= a_in_q[k];
          for (int i = 1; i < k; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign a_left[k] = sk_q[k-1];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DATA_W-1:0] act_in, act_q;
      logic signed [ACC_W-1:0]  psum_in, psum_q;
      logic signed [ACC_W-1:0]  ax, wx;
      if (j == 0) begin : g_a0
        assign act_in = a_left[k];
      end else begin : g_an
        assign act_in = act_w[k][j-1];
      end
      if (k == 0) begin : g_p0
        assign psum_in = '0;
      end else begin : g_pn
        assign psum_in = psum_w[k-1][j];
      end
      assign ax = ACC_W'(act_in);
      assign wx = ACC_W'(w_q[k][j]);
      // MAC: activation moves right, psum moves down, sums wrap.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          act_q  <= '0;
          psum_q <= '0;
        end else begin
          act_q  <= act_in;
          psum_q <= psum_in + ax * wx;
        end
      end
      assign act_w[k][j]  = act_q;
      assign psum_w[k][j] = psum_q;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_dsk
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_d0
      assign col_out[j] = psum_w[N-1][j];
    end else begin : g_dn
      logic signed [ACC_W-1:0] dq [D];
      // Re-align column j with the last column.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < D; i++) dq[i] <= '0;
        end else begin
          dq[0] <= psum_w[N-1][j];
          for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
        end
      end
      assign col_out[j] = dq[D-1];
    end
  end

  // Optional clamp at zero ahead of the output register.
  always_comb begin
    for (int j = 0; j < N; j++) begin
`ifdef SYSTOLIC_RELU_EN
      res[j] = col_out[j][ACC_W-1] ? '0 : col_out[j];
`else
      res[j] = col_out[j];
`endif
    end
  end

  // Output register; holds its last value between results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      out_valid_q <= vld_q[2*N-1];
      out_last_q  <= lst_q[2*N-1];
      if (vld_q[2*N-1])
        for (int j = 0; j < N; j++)
          out_vec_q[j*ACC_W +: ACC_W] <= res[j];
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_vec   = out_vec_q;

endmodule

// File: tb/tb_systolic_array_ws.sv
// tb_systolic_array_ws: directed and random stimulus for systolic_array_ws,
// checked each cycle against a matrix-product reference model.
module tb_systolic_array_ws;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 20;

  typedef int vec_t [N];
  typedef struct {
    int              due;
    logic [N*AW-1:0] vec;
    logic            last;
  } exp_t;
  typedef struct {
    int              cyc;
    logic [N*AW-1:0] vec;
    logic            last;
    logic            rdy;
  } obs_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            w_valid, w_ready, w_reload;
  logic            a_valid, a_ready, a_last;
  logic            out_valid, out_last, busy;
  logic [N*DW-1:0] w_row, a_vec;
  logic [N*AW-1:0] out_vec;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   wm [N][N];
  int   wrows = 0;
  vec_t zv = '{default: 0};
  exp_t expq [$];
  obs_t got [$];

  systolic_array_ws #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_row(w_row), .w_reload(w_reload),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_vec(a_vec), .a_last(a_last),
    .out_valid(out_valid), .out_vec(out_vec),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act,
                       input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d want %0d at cycle %0d",
                  nm, act, req, cyc);
  endtask

  function automatic logic [N*DW-1:0] pk_a(input vec_t v);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(v[k]);
    return r;
  endfunction

  function automatic logic [N*AW-1:0] pk_o(input vec_t v);
    logic [N*AW-1:0] r;
    for (int j = 0; j < N; j++) r[j*AW +: AW] = AW'(v[j]);
    return r;
  endfunction

  function automatic logic [N*AW-1:0] model(input vec_t a);
    logic [N*AW-1:0]       r;
    logic signed [AW-1:0]  t;
    longint                s;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < N; k++)
        s += longint'(a[k]) * longint'(wm[k][j]);
      t = AW'(s);
`ifdef SYSTOLIC_RELU_EN
      if (t < 0) t = '0;
`endif
      r[j*AW +: AW] = t;
    end
    return r;
  endfunction

  task automatic tick(input logic wv, input logic [N*DW-1:0] wr,
                      input logic rl, input logic av,
                      input vec_t a, input logic al);
    @(negedge clk);
    w_valid  = wv;
    w_row    = wr;
    w_reload = rl;
    a_valid  = av;
    a_last   = al;
    a_vec    = pk_a(a);
    if (rl) wrows = 0;
    if (wv && w_ready && wrows < N) begin
      for (int j = 0; j < N; j++)
        wm[wrows][j] = int'($signed(wr[j*DW +: DW]));
      wrows++;
    end
    if (av && a_ready && !rl)
      expq.push_back('{due: cyc + 1 + 2*N, vec: model(a), last: al});
  endtask

  task automatic idle();
    tick(1'b0, '0, 1'b0, 1'b0, zv, 1'b0);
  endtask

  task automatic load_row(input vec_t v);
    tick(1'b1, pk_a(v), 1'b0, 1'b0, zv, 1'b0);
  endtask

  task automatic send(input vec_t v, input logic l);
    tick(1'b0, '0, 1'b0, 1'b1, v, l);
  endtask

  task automatic collect(input int n);
    got.delete();
    repeat (n) begin
      idle();
      if (out_valid)
        got.push_back('{cyc: cyc, vec: out_vec, last: out_last,
                        rdy: a_ready});
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(a_ready && !busy) && n < 8*N + 8) begin
      idle();
      n++;
    end
    check("reach_ready", longint'(a_ready && !busy), 1);
  endtask

  task automatic rst_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_vec"}, out_vec, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_w_ready"}, w_ready, 1);
    check({tag, "_a_ready"}, a_ready, 0);
  endtask

  // Per-cycle scoreboard against the reference queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        check("out_valid", out_valid, 1);
        check("out_vec", out_vec, e.vec);
        check("out_last", out_last, e.last);
      end else begin
        check("out_idle", out_valid, 0);
      end
    end
  end

  initial begin
    int   acc;
    vec_t rv;
    w_valid = 0; w_row = '0; w_reload = 0;
    a_valid = 0; a_vec = '0; a_last = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wm[r][c] = 0;
    #1 reset = 1'b1;
    #1 rst_state("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    load_row('{1, 2});
    load_row('{3, 4});
    check("load_busy", busy, 1);
    check("load_a_ready", a_ready, 0);
    idle();
    check("ready_a_ready", a_ready, 1);
    check("ready_w_ready", w_ready, 0);
    check("ready_busy", busy, 0);

    send('{5, 6}, 1'b1);
    acc = cyc + 1;
    collect(2*N + 3);
    check("t1_count", got.size(), 1);
    if (got.size() == 1) begin
      check("t1_latency", got[0].cyc - acc, 2*N);
      check("t1_vec", got[0].vec, pk_o('{23, 34}));
      check("t1_last", got[0].last, 1);
      check("t1_ready", got[0].rdy, 1);
    end

    send('{1, 0}, 1'b0);
    acc = cyc + 1;
    send('{0, 1}, 1'b0);
    send('{-2, -1}, 1'b1);
    collect(2*N + 4);
    check("t2_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t2_latency", got[0].cyc - acc, 2*N);
      check("t2_b2b", got[2].cyc - got[0].cyc, 2);
      check("t2_vec0", got[0].vec, pk_o('{1, 2}));
      check("t2_vec1", got[1].vec, pk_o('{3, 4}));
`ifdef SYSTOLIC_RELU_EN
      check("t2_vec2", got[2].vec, pk_o('{0, 0}));
`else
      check("t2_vec2", got[2].vec, pk_o('{-5, -8}));
`endif
      check("t2_last0", got[0].last, 0);
      check("t2_last1", got[1].last, 0);
      check("t2_last2", got[2].last, 1);
    end

    tick(1'b0, '0, 1'b1, 1'b1, '{9, 9}, 1'b1);
    idle();
    check("reload_w_ready", w_ready, 1);
    check("reload_a_ready", a_ready, 0);
    check("reload_busy", busy, 0);
    load_row('{-128, -128});
    repeat (3) begin
      idle();
      check("gap_a_ready", a_ready, 0);
      check("gap_busy", busy, 1);
    end
    load_row('{-128, -128});
    idle();
    check("gap_done_a_ready", a_ready, 1);
    send('{-128, -128}, 1'b1);
    collect(2*N + 3);
    check("t3_count", got.size(), 1);
    if (got.size() == 1)
      check("t3_vec", got[0].vec, pk_o('{32768, 32768}));

    tick(1'b0, '0, 1'b1, 1'b0, zv, 1'b0);
    load_row('{1, 0});
    load_row('{0, 1});
    send('{-3, 7}, 1'b1);
    collect(2*N + 3);
    check("t4_count", got.size(), 1);
`ifdef SYSTOLIC_RELU_EN
    if (got.size() == 1)
      check("t4_vec", got[0].vec, pk_o('{0, 7}));
`else
    if (got.size() == 1)
      check("t4_vec", got[0].vec, pk_o('{-3, 7}));
`endif

    for (int r = 0; r < 4; r++) begin
      wait_ready();
      tick(1'b0, '0, 1'b1, 1'b0, zv, 1'b0);
      for (int k = 0; k < N; k++) begin
        repeat ($urandom_range(2)) idle();
        for (int j = 0; j < N; j++)
          rv[j] = int'($urandom_range(255)) - 128;
        load_row(rv);
      end
      for (int i = 0; i < 60; i++) begin
        for (int j = 0; j < N; j++)
          rv[j] = int'($urandom_range(255)) - 128;
        tick(1'b0, '0, 1'b0, $urandom_range(3) != 0, rv,
             $urandom_range(9) == 0);
      end
      for (int n = 0; n < 8*N + 8; n++) begin
        if (a_ready) break;
        idle();
      end
      for (int j = 0; j < N; j++)
        rv[j] = int'($urandom_range(255)) - 128;
      send(rv, 1'b1);
      repeat (2*N + 4) idle();
    end

    wait_ready();
    send('{3, -4}, 1'b0);
    send('{-7, 2}, 1'b1);
    idle();
    @(negedge clk);
    #2 reset = 1'b1;
    expq.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wm[r][c] = 0;
    wrows = 0;
    #1 rst_state("midrst");
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3*N + 2) idle();
    rst_state("postrst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/systolic_array_ws.md
Name: systolic_array_ws

Overview:
- Parameterised N x N weight-stationary systolic matrix unit. Successor to the fixed 2x2 PE grid.
- Loads an N x N weight matrix W row by row, then streams activation vectors a. For each vector it computes out[j] = sum_k a[k]*W[k][j].
- Input skew, output deskew, load/stream/drain sequencing and valid/last tracking are all internal, so the controller sees plain unskewed vectors.
- Sits between the unified activation buffer and the accumulator/writeback stage.

Parameters:
- N, 4, array dimension (rows = columns = N), N >= 2.
- DATA_W, 8, signed two's-complement width of weights and activations.
- ACC_W, 20, signed width of partial sums and outputs; must be >= 2*DATA_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- w_valid  in  1  w_row holds a valid weight row.
- w_ready  out  1  weight row accepted when w_valid && w_ready.
- w_row  in  N*DATA_W  row k of W; element j at bits [j*DATA_W +: DATA_W].
- w_reload  in  1  single-cycle pulse; READY -> IDLE so new weights can be loaded.
- a_valid  in  1  a_vec valid.
- a_ready  out  1  vector accepted when a_valid && a_ready.
- a_vec  in  N*DATA_W  activation vector; element k at bits [k*DATA_W +: DATA_W].
- a_last  in  1  qualifies the accepted vector as last of a batch.
- out_valid  out  1  out_vec valid (one-cycle strobe per result; no backpressure).
- out_vec  out  N*ACC_W  result; element j at bits [j*ACC_W +: ACC_W].
- out_last  out  1  out_valid result belongs to the a_last vector.
- busy  out  1  high in LOAD, STREAM, DRAIN.

Behaviour:
- Reset (async):
  - state = IDLE; all PE weights, activation and psum registers, skew/deskew registers and counters = 0.
  - out_valid = 0, out_vec = 0, out_last = 0, busy = 0, w_ready = 1, a_ready = 0.
  - Reset mid-operation abandons in-flight vectors: no out_valid is produced for them.
- FSM:
  - IDLE: w_ready = 1. An accepted row is written to PE row 0 and the state moves to LOAD with row_cnt = 1.
  - LOAD: w_ready = 1. Each accepted row k is written to PE row row_cnt, then row_cnt increments. After row N-1 is accepted, the state moves to READY. Gaps in w_valid are allowed.
  - READY: a_ready = 1, w_ready = 0.
    - Accepted vector -> STREAM, or -> DRAIN if a_last is set.
    - w_reload -> IDLE. Weights are retained until overwritten.
    - w_reload has priority over a simultaneous a_valid; a_ready stays 1 but that vector is dropped.
  - STREAM: a_ready = 1. One vector per cycle at full throughput. Accepting a vector with a_last -> DRAIN. w_reload is ignored.
  - DRAIN: a_ready = 0. drain_cnt counts 2N cycles from the last accept, then the state moves to READY.
- Datapath:
  - Activation k passes through k skew registers, enters PE(k,0) and moves one column right per cycle.
  - Psums move one row down per cycle; psum_in of row 0 is 0.
  - Column j output passes through N-1-j deskew registers, then the output register.
- Latency: a vector accepted at edge t produces out_valid at edge t+2N. Back-to-back inputs give back-to-back outputs.
- Result ordering: out_valid/out_last are a 2N-deep shift of (accept, a_last), so results emerge in input order.
- Arithmetic:
  - Products are DATA_W x DATA_W signed, sign-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W; there is no saturation in the base configuration.
- Bubbles:
  - Cycles without an accept inject zero activations and a 0 valid bit.
  - Out_vec contents are undefined when out_valid = 0; the implementation holds the last value.

Optional Feature:
- Macro SYSTOLIC_RELU_EN.
- When defined: each out_vec element is max(x, 0) before the output register. Latency is unchanged.
- When undefined: the raw signed sum is output.

Test Plan:
- N=2, DATA_W=8, ACC_W=20: load rows {W01=2, W00=1} then {W11=4, W10=3}, send a=[5,6] with a_last -> out_valid at accept+4 cycles with out_vec=[23,34], out_last=1, then READY.
- Same weights, 3 back-to-back vectors [1,0],[0,1],[-2,-1] (last on 3rd) -> consecutive out_valid with [1,2],[3,4],[-5,-8]; out_last only on the 3rd.
- Same weights, a=[-128,-128] with W all -128 -> out_vec=[32768,32768] exact, no wrap.
- Weight load with w_valid gaps (row, 3 idle, row) -> a_ready stays 0 until 2nd row is accepted; w_reload in READY -> IDLE, w_ready=1, new weights take effect.
- Reset asserted during DRAIN with 2 vectors in flight -> outputs 0 immediately, no out_valid afterwards, state IDLE, weights zero (result 0 until reloaded).
- SYSTOLIC_RELU_EN defined, W=identity, a=[-3,7] -> out_vec=[0,7]; undefined -> [-3,7].
